// File: rtl/addersub_pkg.sv
// rtl/addersub_pkg.sv - shared state and opcode types for the adder/subtractor arbiter
package addersub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } arb_state_t;

   typedef enum logic {
      OP_ADD = 1'b0,
      OP_SUB = 1'b1
   } op_e;

endpackage

// File: rtl/addersub_arbiter_if.sv
// rtl/addersub_arbiter_if.sv - two requester ports and one result port; ADDERSUB_OVF_EN adds res_ovf
interface addersub_arbiter_if #(
   parameter int N = 4
);
   logic         req0_valid;
   logic         req0_ready;
   logic [N-1:0] req0_a;
   logic [N-1:0] req0_b;
   logic         req0_cin;
   logic         req0_sub;

   logic         req1_valid;
   logic         req1_ready;
   logic [N-1:0] req1_a;
   logic [N-1:0] req1_b;
   logic         req1_cin;
   logic         req1_sub;

   logic         res_valid;
   logic         res_ready;
   logic [N-1:0] res_s;
   logic         res_cout;
   logic         res_id;
`ifdef ADDERSUB_OVF_EN
   logic         res_ovf;
`endif

   modport slave (
      input  req0_valid, req0_a, req0_b, req0_cin, req0_sub,
      output req0_ready,
      input  req1_valid, req1_a, req1_b, req1_cin, req1_sub,
      output req1_ready,
      input  res_ready,
      output res_valid, res_s, res_cout, res_id
`ifdef ADDERSUB_OVF_EN
      , output res_ovf
`endif
   );

   modport master (
      output req0_valid, req0_a, req0_b, req0_cin, req0_sub,
      input  req0_ready,
      output req1_valid, req1_a, req1_b, req1_cin, req1_sub,
      input  req1_ready,
      output res_ready,
      input  res_valid, res_s, res_cout, res_id
`ifdef ADDERSUB_OVF_EN
      , input res_ovf
`endif
   );

endinterface

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - combinational two-way round-robin grant; a lone requester always wins
module rr_arbiter2 (
   input  logic       i_valid0,
   input  logic       i_valid1,
   input  logic       i_ptr,
   output logic [1:0] o_grant
);

   // i_ptr only breaks ties when both requesters are valid
   assign o_grant[0] = i_valid0 & (~i_valid1 | ~i_ptr);
   assign o_grant[1] = i_valid1 & (~i_valid0 |  i_ptr);

endmodule

// File: rtl/addersub_arbiter.sv
// rtl/addersub_arbiter.sv - shared N-bit add/sub datapath for two requesters, IDLE/EXEC/DONE FSM
// Optional signed overflow output enabled by ADDERSUB_OVF_EN.
module addersub_arbiter
   import addersub_pkg::*;
#(
   parameter int N = 4
) (
   input logic               clk,
   input logic               rst,
   addersub_arbiter_if.slave bus
);

   arb_state_t   r_state;
   logic         r_ptr;
   logic [N-1:0] r_a;
   logic [N-1:0] r_b;
   logic         r_cin;
   op_e          r_op;
   logic         r_id;
   logic [N-1:0] r_s;
   logic         r_cout;
   logic         r_res_id;
   logic         r_res_valid;

   logic [1:0]   w_grant;
   logic         w_idle;
   logic [N-1:0] w_b_eff;
   logic [N:0]   w_sum;

   rr_arbiter2 u_rr_arbiter2 (
      .i_valid0 (bus.req0_valid),
      .i_valid1 (bus.req1_valid),
      .i_ptr    (r_ptr),
      .o_grant  (w_grant)
   );

   // ready is forced low while reset is asserted even though the state already reads IDLE
   assign w_idle         = (r_state == IDLE) && !rst;
   assign bus.req0_ready = w_idle && w_grant[0];
   assign bus.req1_ready = w_idle && w_grant[1];

   assign w_b_eff = (r_op == OP_SUB) ? ~r_b : r_b;
   assign w_sum   = {1'b0, r_a} + {1'b0, w_b_eff} + {{N{1'b0}}, r_cin};

   assign bus.res_valid = r_res_valid;
   assign bus.res_s     = r_s;
   assign bus.res_cout  = r_cout;
   assign bus.res_id    = r_res_id;

`ifdef ADDERSUB_OVF_EN
   logic r_ovf;
   logic w_ovf;
   assign w_ovf       = (r_a[N-1] == w_b_eff[N-1]) && (w_sum[N-1] != r_a[N-1]);
   assign bus.res_ovf = r_ovf;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_ptr       <= 1'b0;
         r_a         <= '0;
         r_b         <= '0;
         r_cin       <= 1'b0;
         r_op        <= OP_ADD;
         r_id        <= 1'b0;
         r_s         <= '0;
         r_cout      <= 1'b0;
         r_res_id    <= 1'b0;
         r_res_valid <= 1'b0;
`ifdef ADDERSUB_OVF_EN
         r_ovf       <= 1'b0;
`endif
      end else begin
         case (r_state)
            IDLE: begin
               if (w_grant != 2'b00) begin
                  r_id    <= w_grant[1];
                  r_a     <= w_grant[1] ? bus.req1_a   : bus.req0_a;
                  r_b     <= w_grant[1] ? bus.req1_b   : bus.req0_b;
                  r_cin   <= w_grant[1] ? bus.req1_cin : bus.req0_cin;
                  r_op    <= op_e'(w_grant[1] ? bus.req1_sub : bus.req0_sub);
                  r_state <= EXEC;
               end
            end
            EXEC: begin
               r_s         <= w_sum[N-1:0];
               r_cout      <= w_sum[N];
               r_res_id    <= r_id;
               r_res_valid <= 1'b1;
`ifdef ADDERSUB_OVF_EN
               r_ovf       <= w_ovf;
`endif
               r_state     <= DONE;
            end
            DONE: begin
               if (bus.res_ready) begin
                  r_res_valid <= 1'b0;
                  r_ptr       <= ~r_res_id;
                  r_state     <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_addersub_arbiter.sv
// tb/tb_addersub_arbiter.sv - randomized self-checking bench for addersub_arbiter (N = 4)
module tb_addersub_arbiter;

   localparam int N = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   addersub_arbiter_if #(.N(N)) bus ();

   addersub_arbiter #(.N(N)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int   n_cmp  = 0;
   int   n_fail = 0;
   logic ptr_m;
   int   got_order[$];

   logic [3:0] op_a   [2][32];
   logic [3:0] op_b   [2][32];
   logic       op_cin [2][32];
   logic       op_sub [2][32];

   function automatic logic [4:0] ref_sum(input logic [3:0] a, b, input logic cin, sub);
      int t;
      t = int'(a) + (sub ? (15 - int'(b)) : int'(b)) + int'(cin);
      return t[4:0];
   endfunction

   function automatic logic ref_ovf(input logic [3:0] a, b, input logic cin, sub);
      int sa, sb, r;
      sa = a[3] ? int'(a) - 16 : int'(a);
      sb = b[3] ? int'(b) - 16 : int'(b);
      r  = sa + (sub ? (-sb - 1) : sb) + int'(cin);
      return (r > 7) || (r < -8);
   endfunction

   task automatic set_req(input int x, input logic v, input logic [3:0] a, b, input logic cin, sub);
      if (x == 0) begin
         bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; bus.req0_cin = cin; bus.req0_sub = sub;
      end else begin
         bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; bus.req1_cin = cin; bus.req1_sub = sub;
      end
   endtask

   task automatic issue(input int x, input logic [3:0] a, b, input logic cin, sub, output bit acc);
      @(negedge clk);
      set_req(x, 1'b1, a, b, cin, sub);
      acc = 1'b0;
      for (int i = 0; i < 20; i++) begin
         #1;
         if ((x == 0 && bus.req0_ready) || (x == 1 && bus.req1_ready)) begin
            acc = 1'b1;
            break;
         end
         @(negedge clk);
      end
      @(posedge clk);
      #1 set_req(x, 1'b0, a, b, cin, sub);
   endtask

   task automatic collect(output int lat, output logic [3:0] s, output logic cout, id, ovf);
      lat = -1; s = '0; cout = 1'b0; id = 1'b0; ovf = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (bus.res_valid) begin
            lat = i; s = bus.res_s; cout = bus.res_cout; id = bus.res_id;
`ifdef ADDERSUB_OVF_EN
            ovf = bus.res_ovf;
`endif
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.res_ready = 1'b1;
      set_req(0, 1'b1, 4'd1, 4'd2, 1'b0, 1'b0);
      set_req(1, 1'b1, 4'd3, 4'd4, 1'b0, 1'b0);
      #2;
      n_cmp++; if (bus.res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_res_valid got %b want 0", bus.res_valid); end
      n_cmp++; if (bus.res_s !== 4'd0) begin n_fail++; $display("FAIL reset_res_s got %0d want 0", bus.res_s); end
      n_cmp++; if (bus.res_cout !== 1'b0) begin n_fail++; $display("FAIL reset_res_cout got %b want 0", bus.res_cout); end
      n_cmp++; if (bus.res_id !== 1'b0) begin n_fail++; $display("FAIL reset_res_id got %b want 0", bus.res_id); end
      n_cmp++; if ({bus.req1_ready, bus.req0_ready} !== 2'b00) begin n_fail++; $display("FAIL reset_ready got %b want 00", {bus.req1_ready, bus.req0_ready}); end
`ifdef ADDERSUB_OVF_EN
      n_cmp++; if (bus.res_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_res_ovf got %b want 0", bus.res_ovf); end
`endif
      set_req(0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
      set_req(1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
      ptr_m = 1'b0;
   endtask

   task automatic test_single_add();
      bit acc; int lat; logic [3:0] s; logic c, id, ov;
      issue(0, 4'd3, 4'd5, 1'b0, 1'b0, acc);
      n_cmp++; if (acc !== 1'b1) begin n_fail++; $display("FAIL add_accept got %b want 1", acc); end
      collect(lat, s, c, id, ov);
      n_cmp++; if (lat !== 2) begin n_fail++; $display("FAIL add_latency got %0d want 2", lat); end
      n_cmp++; if (s !== 4'd8) begin n_fail++; $display("FAIL add_s got %0d want 8", s); end
      n_cmp++; if (c !== 1'b0) begin n_fail++; $display("FAIL add_cout got %b want 0", c); end
      n_cmp++; if (id !== 1'b0) begin n_fail++; $display("FAIL add_id got %b want 0", id); end
      @(negedge clk);
      n_cmp++; if (bus.res_valid !== 1'b0) begin n_fail++; $display("FAIL add_one_cycle_valid got %b want 0", bus.res_valid); end
      ptr_m = 1'b1;
   endtask

   task automatic test_sub_borrow();
      bit acc; int lat; logic [3:0] s; logic c, id, ov;
      issue(1, 4'd2, 4'd5, 1'b1, 1'b1, acc);
      collect(lat, s, c, id, ov);
      n_cmp++; if (s !== 4'd13) begin n_fail++; $display("FAIL sub_s got %0d want 13", s); end
      n_cmp++; if (c !== 1'b0) begin n_fail++; $display("FAIL sub_cout got %b want 0", c); end
      n_cmp++; if (id !== 1'b1) begin n_fail++; $display("FAIL sub_id got %b want 1", id); end
      ptr_m = 1'b0;
   endtask

   task automatic test_wrap();
      bit acc; int lat; logic [3:0] s; logic c, id, ov;
      issue(0, 4'd15, 4'd1, 1'b0, 1'b0, acc);
      collect(lat, s, c, id, ov);
      n_cmp++; if (s !== 4'd0) begin n_fail++; $display("FAIL wrap_s got %0d want 0", s); end
      n_cmp++; if (c !== 1'b1) begin n_fail++; $display("FAIL wrap_cout got %b want 1", c); end
      ptr_m = 1'b1;
`ifdef ADDERSUB_OVF_EN
      issue(1, 4'd7, 4'd1, 1'b0, 1'b0, acc);
      collect(lat, s, c, id, ov);
      n_cmp++; if (s !== 4'd8) begin n_fail++; $display("FAIL ovf_s got %0d want 8", s); end
      n_cmp++; if (ov !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got %b want 1", ov); end
      ptr_m = 1'b0;
`endif
   endtask

   task automatic run_stream(input int n0, n1, input bit gaps);
      int idx[2]; int cnt[2]; bit pres[2]; bit busy; int done_cnt; int g;
      logic [1:0] exp_rdy; logic [4:0] e_sum; logic e_id, e_ovf;
      logic [4:0] q_sum[$]; logic q_id[$]; logic q_ovf[$];
      idx = '{0, 0}; cnt = '{n0, n1}; pres = '{1'b0, 1'b0}; busy = 1'b0; done_cnt = 0;
      got_order.delete();
      for (int x = 0; x < 2; x++)
         for (int i = 0; i < 32; i++) begin
            op_a[x][i] = 4'($urandom); op_b[x][i] = 4'($urandom);
            op_cin[x][i] = 1'($urandom); op_sub[x][i] = 1'($urandom);
         end
      for (int c = 0; c < 600 && done_cnt < n0 + n1; c++) begin
         @(negedge clk);
         for (int x = 0; x < 2; x++) begin
            if (!pres[x] && idx[x] < cnt[x] && (!gaps || $urandom_range(0, 2) != 0)) pres[x] = 1'b1;
            set_req(x, pres[x], op_a[x][idx[x]], op_b[x][idx[x]], op_cin[x][idx[x]], op_sub[x][idx[x]]);
         end
         bus.res_ready = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
         #1;
         g = -1;
         if (!busy && (pres[0] || pres[1])) g = (pres[0] && pres[1]) ? int'(ptr_m) : (pres[1] ? 1 : 0);
         exp_rdy = (g < 0) ? 2'b00 : (g == 1 ? 2'b10 : 2'b01);
         n_cmp++;
         if ({bus.req1_ready, bus.req0_ready} !== exp_rdy) begin
            n_fail++; $display("FAIL stream_ready cycle %0d got %b want %b", c, {bus.req1_ready, bus.req0_ready}, exp_rdy);
         end
         if (bus.res_valid) begin
            if (q_id.size() == 0) begin
               n_cmp++; n_fail++; $display("FAIL stream_spurious_result cycle %0d got valid want none", c);
            end else begin
               e_sum = q_sum[0]; e_id = q_id[0]; e_ovf = q_ovf[0];
               n_cmp++; if ({bus.res_cout, bus.res_s} !== e_sum) begin n_fail++; $display("FAIL stream_result cycle %0d got %h want %h", c, {bus.res_cout, bus.res_s}, e_sum); end
               n_cmp++; if (bus.res_id !== e_id) begin n_fail++; $display("FAIL stream_id cycle %0d got %b want %b", c, bus.res_id, e_id); end
`ifdef ADDERSUB_OVF_EN
               n_cmp++; if (bus.res_ovf !== e_ovf) begin n_fail++; $display("FAIL stream_ovf cycle %0d got %b want %b", c, bus.res_ovf, e_ovf); end
`endif
               if (bus.res_ready) begin
                  void'(q_sum.pop_front()); void'(q_id.pop_front()); void'(q_ovf.pop_front());
                  got_order.push_back(int'(bus.res_id));
                  busy = 1'b0; ptr_m = ~e_id; done_cnt++;
               end
            end
         end
         if (g >= 0) begin
            q_sum.push_back(ref_sum(op_a[g][idx[g]], op_b[g][idx[g]], op_cin[g][idx[g]], op_sub[g][idx[g]]));
            q_ovf.push_back(ref_ovf(op_a[g][idx[g]], op_b[g][idx[g]], op_cin[g][idx[g]], op_sub[g][idx[g]]));
            q_id.push_back(g[0]);
            busy = 1'b1;
         end
         @(posedge clk);
         if (g >= 0) begin pres[g] = 1'b0; idx[g]++; end
      end
      n_cmp++; if (done_cnt != n0 + n1) begin n_fail++; $display("FAIL stream_complete got %0d want %0d", done_cnt, n0 + n1); end
      #1;
      set_req(0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
      set_req(1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
      bus.res_ready = 1'b1;
   endtask

   task automatic test_fairness();
      int exp_order[4];
      exp_order = '{0, 1, 0, 1};
      @(negedge clk); rst = 1'b1; @(negedge clk); rst = 1'b0; ptr_m = 1'b0;
      run_stream(2, 2, 1'b0);
      for (int i = 0; i < 4; i++) begin
         n_cmp++;
         if (i >= got_order.size() || got_order[i] != exp_order[i]) begin
            n_fail++; $display("FAIL fairness_order[%0d] got %0d want %0d", i, (i < got_order.size()) ? got_order[i] : -1, exp_order[i]);
         end
      end
   endtask

   task automatic test_back_pressure();
      bit acc; int lat; logic [3:0] s; logic c, id, ov;
      bus.res_ready = 1'b0;
      issue(0, 4'd9, 4'd4, 1'b0, 1'b0, acc);
      collect(lat, s, c, id, ov);
      n_cmp++; if ({c, s} !== 5'd13) begin n_fail++; $display("FAIL bp_first got %h want d", {c, s}); end
      set_req(0, 1'b1, 4'd1, 4'd1, 1'b0, 1'b0);
      set_req(1, 1'b1, 4'd6, 4'd3, 1'b1, 1'b1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); #1;
         n_cmp++;
         if ({bus.res_valid, bus.res_cout, bus.res_s, bus.res_id, bus.req1_ready, bus.req0_ready} !== {1'b1, 5'd13, 1'b0, 2'b00}) begin
            n_fail++; $display("FAIL bp_hold cycle %0d got v=%b s=%0d c=%b id=%b rdy=%b%b want v=1 s=13 c=0 id=0 rdy=00", i,
                               bus.res_valid, bus.res_s, bus.res_cout, bus.res_id, bus.req1_ready, bus.req0_ready);
         end
      end
      bus.res_ready = 1'b1;
      @(negedge clk); #1;
      n_cmp++; if ({bus.req1_ready, bus.req0_ready} !== 2'b10) begin n_fail++; $display("FAIL bp_next_grant got %b want 10", {bus.req1_ready, bus.req0_ready}); end
      @(posedge clk); #1;
      set_req(0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
      set_req(1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
      collect(lat, s, c, id, ov);
      n_cmp++; if ({id, c, s} !== {1'b1, 5'd19}) begin n_fail++; $display("FAIL bp_second got id=%b %h want id=1 13", id, {c, s}); end
      @(negedge clk);
      ptr_m = 1'b0;
   endtask

   task automatic test_reset_mid_exec();
      bit acc; int lat; logic [3:0] s; logic c, id, ov;
      issue(1, 4'd4, 4'd4, 1'b0, 1'b0, acc);
      rst = 1'b1;
      #2;
      n_cmp++; if ({bus.res_valid, bus.req1_ready, bus.req0_ready} !== 3'b000) begin n_fail++; $display("FAIL rst_exec_outputs got %b want 000", {bus.res_valid, bus.req1_ready, bus.req0_ready}); end
      @(negedge clk); rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_cmp++; if (bus.res_valid !== 1'b0) begin n_fail++; $display("FAIL rst_exec_no_result cycle %0d got %b want 0", i, bus.res_valid); end
      end
      set_req(0, 1'b1, 4'd5, 4'd2, 1'b1, 1'b1);
      set_req(1, 1'b1, 4'd1, 4'd1, 1'b0, 1'b0);
      #1;
      n_cmp++; if ({bus.req1_ready, bus.req0_ready} !== 2'b01) begin n_fail++; $display("FAIL rst_exec_grant got %b want 01", {bus.req1_ready, bus.req0_ready}); end
      @(posedge clk); #1;
      set_req(0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
      set_req(1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
      collect(lat, s, c, id, ov);
      n_cmp++; if ({id, c, s} !== {1'b0, 5'd19}) begin n_fail++; $display("FAIL rst_exec_result got id=%b %h want id=0 13", id, {c, s}); end
      @(negedge clk);
      ptr_m = 1'b1;
   endtask

   task automatic test_random();
      run_stream(12, 12, 1'b1);
   endtask

   initial begin
      test_reset();
      test_single_add();
      test_sub_borrow();
      test_wrap();
      test_fairness();
      test_back_pressure();
      test_reset_mid_exec();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog");
   end

endmodule
